// File: rtl/zube_fifo_bridge.sv
// Z80 I/O-port to Wishbone mailbox: RX FIFO carries Z80 writes to the SoC, TX FIFO carries SoC writes to the Z80.
// State | meaning:  ST_IDLE = transceiver off | ST_DRIVE = bus_out driven to Z80 until synced read strobe rises.
module zube_fifo_bridge #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [7:0]  Z80_RESET_PORT = 8'h80,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        z80_write_strobe_b,
    input  logic        z80_read_strobe_b,
    input  logic [7:0]  z80_address_bus,
    input  logic [7:0]  z80_data_bus_in,
    output logic [7:0]  z80_data_bus_out,
    output logic        z80_bus_dir,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic        wb_stall_out,
    output logic [31:0] wb_data_out,
    output logic        irq_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_DRIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]      wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0]      rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0][7:0] addr_sync_q, addr_sync_d;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
    logic                        wr_prev_q, wr_prev_d;
    logic                        rd_prev_q, rd_prev_d;

    logic [7:0]    port_q, port_d;
    logic          irq_en_q, irq_en_d;
    logic          rx_ovf_q, rx_ovf_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          ack_q, ack_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          irq_q, irq_d;
    logic [7:0]    bus_out_q, bus_out_d;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [LW-1:0] rx_level_q, rx_level_d, tx_level_q, tx_level_d;

    logic       wr_s, rd_s;
    logic [7:0] z_addr, z_data, port_stat;
    logic       z_wr_data, z_rd_data, z_rd_stat, z_rd_evt;
    logic       hit_ctrl, hit_data, hit_stat, wb_req, wb_go, wb_wr, wb_rd;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push_req, rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
    logic       unused_wb_bits;

    assign unused_wb_bits = ^wb_data_in[31:9];

    // Strobe, address and data share one pipeline so an event always sees the matching address/data.
    always_comb begin
        wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], z80_write_strobe_b};
        rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], z80_read_strobe_b};
        addr_sync_d = {addr_sync_q[SYNC_STAGES-2:0], z80_address_bus};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], z80_data_bus_in};
        wr_prev_d   = wr_sync_q[SYNC_STAGES-1];
        rd_prev_d   = rd_sync_q[SYNC_STAGES-1];
    end

    assign wr_s      = wr_sync_q[SYNC_STAGES-1];
    assign rd_s      = rd_sync_q[SYNC_STAGES-1];
    assign z_addr    = addr_sync_q[SYNC_STAGES-1];
    assign z_data    = data_sync_q[SYNC_STAGES-1];
    assign port_stat = port_q + 8'd1;

    assign z_wr_data = wr_prev_q & ~wr_s & (z_addr == port_q);
    assign z_rd_data = rd_prev_q & ~rd_s & (z_addr == port_q);
    assign z_rd_stat = rd_prev_q & ~rd_s & (z_addr == port_stat);
    assign z_rd_evt  = z_rd_data | z_rd_stat;

    assign hit_ctrl = (wb_addr_in == BASE_ADDRESS);
    assign hit_data = (wb_addr_in == BASE_ADDRESS + 32'd4);
    assign hit_stat = (wb_addr_in == BASE_ADDRESS + 32'd8);
    assign wb_req   = wb_cyc_in & wb_stb_in & (hit_ctrl | hit_data | hit_stat);
    // A request held through its ack cycle is serviced only once.
    assign wb_go    = wb_req & ~ack_q;
    assign wb_wr    = wb_go & wb_we_in;
    assign wb_rd    = wb_go & ~wb_we_in;

    assign rx_empty = (rx_level_q == '0);
    assign rx_full  = (rx_level_q == FULL_LVL);
    assign tx_empty = (tx_level_q == '0);
    assign tx_full  = (tx_level_q == FULL_LVL);

    assign rx_push_req = z_wr_data;
    assign rx_pop      = wb_rd & hit_data & ~rx_empty;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign tx_push_req = wb_wr & hit_data;
    assign tx_pop      = z_rd_data & ~tx_empty;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    always_comb begin
        port_d      = port_q;
        irq_en_d    = irq_en_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        bus_out_d   = bus_out_q;
        wb_data_d   = 32'h0;
        ack_d       = wb_go;
        irq_d       = irq_en_q & ~rx_empty;

        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
        rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);
        tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);

        // Set beats write-1-to-clear in the same cycle.
        rx_ovf_d = (rx_ovf_q & ~(wb_wr & hit_stat & wb_data_in[4])) | (rx_push_req & ~rx_push);
        tx_ovf_d = (tx_ovf_q & ~(wb_wr & hit_stat & wb_data_in[5])) | (tx_push_req & ~tx_push);

        if (wb_wr && hit_ctrl) begin
            port_d   = wb_data_in[7:0];
            irq_en_d = wb_data_in[8];
        end

        if (wb_rd) begin
            if (hit_ctrl) begin
                wb_data_d = {23'b0, irq_en_q, port_q};
            end else if (hit_data) begin
                wb_data_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_mem_q[rx_rd_ptr_q]};
            end else begin
                wb_data_d = {8'b0, 8'(tx_level_q), 8'(rx_level_q), 2'b0,
                             tx_ovf_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};
            end
        end

        if (z_rd_data) begin
            bus_out_d = tx_empty ? 8'hFF : tx_mem_q[tx_rd_ptr_q];
        end else if (z_rd_stat) begin
            bus_out_d = {6'b0, ~rx_full, ~tx_empty};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (z_rd_evt) state_d = ST_DRIVE;
            ST_DRIVE: if (rd_s)     state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        z80_bus_dir = (state_q == ST_DRIVE);
    end

    assign z80_data_bus_out = bus_out_q;
    assign wb_ack_out       = ack_q;
    assign wb_stall_out     = 1'b0;
    assign wb_data_out      = wb_data_q;
    assign irq_out          = irq_q;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= z_data;
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wb_data_in[7:0];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_sync_q   <= '1;
            rd_sync_q   <= '1;
            addr_sync_q <= '0;
            data_sync_q <= '0;
            wr_prev_q   <= 1'b1;
            rd_prev_q   <= 1'b1;
            port_q      <= Z80_RESET_PORT;
            irq_en_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            ack_q       <= 1'b0;
            wb_data_q   <= 32'h0;
            irq_q       <= 1'b0;
            bus_out_q   <= 8'h0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_level_q  <= '0;
            tx_level_q  <= '0;
        end else begin
            wr_sync_q   <= wr_sync_d;
            rd_sync_q   <= rd_sync_d;
            addr_sync_q <= addr_sync_d;
            data_sync_q <= data_sync_d;
            wr_prev_q   <= wr_prev_d;
            rd_prev_q   <= rd_prev_d;
            port_q      <= port_d;
            irq_en_q    <= irq_en_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            ack_q       <= ack_d;
            wb_data_q   <= wb_data_d;
            irq_q       <= irq_d;
            bus_out_q   <= bus_out_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_level_q  <= rx_level_d;
            tx_level_q  <= tx_level_d;
        end
    end

endmodule

// File: tb/tb_zube_fifo_bridge.sv
// Directed bench for zube_fifo_bridge; FIFO contents and flags are tracked in a queue-based model.
module tb_zube_fifo_bridge;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        z80_write_strobe_b, z80_read_strobe_b;
    logic [7:0]  z80_address_bus, z80_data_bus_in, z80_data_bus_out;
    logic        z80_bus_dir;
    logic        wb_cyc_in, wb_stb_in, wb_we_in;
    logic [31:0] wb_addr_in, wb_data_in, wb_data_out;
    logic        wb_ack_out, wb_stall_out, irq_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_rx_ovf, m_tx_ovf, m_irq_en;
    logic [7:0] m_port;

    zube_fifo_bridge #(
        .BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH), .Z80_RESET_PORT(8'h80), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_b(reset_b),
        .z80_write_strobe_b(z80_write_strobe_b), .z80_read_strobe_b(z80_read_strobe_b),
        .z80_address_bus(z80_address_bus), .z80_data_bus_in(z80_data_bus_in),
        .z80_data_bus_out(z80_data_bus_out), .z80_bus_dir(z80_bus_dir),
        .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
        .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .wb_ack_out(wb_ack_out), .wb_stall_out(wb_stall_out),
        .wb_data_out(wb_data_out), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [7:0] rl, tl;
        rl = 8'(rx_q.size());
        tl = 8'(tx_q.size());
        return {8'b0, tl, rl, 2'b0, m_tx_ovf, m_rx_ovf,
                tl == 8'(DEPTH), tl == 8'd0, rl == 8'(DEPTH), rl == 8'd0};
    endfunction

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_rx_ovf = 1'b0;
        m_tx_ovf = 1'b0;
        m_irq_en = 1'b0;
        m_port   = 8'h80;
    endtask

    task automatic wb(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp;
        exp = 32'h0;
        if (!we) begin
            if (a == BASE) exp = {23'b0, m_irq_en, m_port};
            else if (a == BASE + 32'd4) begin
                if (rx_q.size() > 0) exp = {23'b0, 1'b1, rx_q.pop_front()};
            end else if (a == BASE + 32'd8) exp = exp_status();
        end else begin
            if (a == BASE) begin
                m_port   = d[7:0];
                m_irq_en = d[8];
            end else if (a == BASE + 32'd4) begin
                if (tx_q.size() < DEPTH) tx_q.push_back(d[7:0]);
                else m_tx_ovf = 1'b1;
            end else if (a == BASE + 32'd8) begin
                if (d[4]) m_rx_ovf = 1'b0;
                if (d[5]) m_tx_ovf = 1'b0;
            end
        end
        @(negedge clk);
        wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = we; wb_addr_in = a; wb_data_in = d;
        @(posedge clk); #1;
        check("wb_ack", wb_ack_out, 32'd1);
        check("wb_rdata", wb_data_out, exp);
        @(negedge clk);
        wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
        @(posedge clk); #1;
        check("wb_ack_drop", wb_ack_out, 32'd0);
    endtask

    task automatic z80_wr(input logic [7:0] a, input logic [7:0] d);
        if (a == m_port) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(d);
            else m_rx_ovf = 1'b1;
        end
        @(negedge clk);
        z80_address_bus = a; z80_data_bus_in = d; z80_write_strobe_b = 1'b0;
        repeat (5) @(negedge clk);
        z80_write_strobe_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic z80_rd(input logic [7:0] a);
        logic       hit;
        logic [7:0] exp, sp;
        hit = 1'b0;
        exp = 8'h00;
        sp  = m_port + 8'd1;
        if (a == m_port) begin
            hit = 1'b1;
            if (tx_q.size() > 0) exp = tx_q.pop_front();
            else exp = 8'hFF;
        end else if (a == sp) begin
            hit = 1'b1;
            exp = {6'b0, rx_q.size() < DEPTH, tx_q.size() > 0};
        end
        @(negedge clk);
        z80_address_bus = a; z80_read_strobe_b = 1'b0;
        @(negedge clk);
        check("z80_dir_early", z80_bus_dir, 32'd0);
        repeat (4) @(negedge clk);
        check("z80_dir_hold", z80_bus_dir, {31'b0, hit});
        if (hit) check("z80_bus_out", z80_data_bus_out, {24'b0, exp});
        z80_read_strobe_b = 1'b1;
        @(negedge clk);
        check("z80_dir_tail", z80_bus_dir, {31'b0, hit});
        repeat (4) @(negedge clk);
        check("z80_dir_fall", z80_bus_dir, 32'd0);
    endtask

    initial begin
        logic [31:0] exp;
        reset_b = 1'b0;
        z80_write_strobe_b = 1'b1; z80_read_strobe_b = 1'b1;
        z80_address_bus = 8'h00; z80_data_bus_in = 8'h00;
        wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
        wb_addr_in = 32'h0; wb_data_in = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_bus_out", z80_data_bus_out, 32'h0);
        check("rst_bus_dir", z80_bus_dir, 32'h0);
        check("rst_ack", wb_ack_out, 32'h0);
        check("rst_stall", wb_stall_out, 32'h0);
        check("rst_wb_data", wb_data_out, 32'h0);
        check("rst_irq", irq_out, 32'h0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        wb(1'b0, BASE + 32'd8, 32'h0);
        wb(1'b0, BASE, 32'h0);

        // Z80 -> SoC: three bytes, then drain past empty
        z80_wr(8'h80, 8'h11);
        z80_wr(8'h80, 8'h22);
        z80_wr(8'h80, 8'h33);
        z80_wr(8'h81, 8'h99);
        wb(1'b0, BASE + 32'd8, 32'h0);
        for (int i = 0; i < 4; i++) wb(1'b0, BASE + 32'd4, 32'h0);

        // SoC -> Z80: overfill TX, then drain past empty
        for (int i = 0; i <= DEPTH; i++) wb(1'b1, BASE + 32'd4, 32'hA0 + 32'(i));
        wb(1'b0, BASE + 32'd8, 32'h0);
        z80_rd(8'h81);
        for (int i = 0; i <= DEPTH; i++) z80_rd(8'h80);
        wb(1'b1, BASE + 32'd8, 32'h30);
        wb(1'b0, BASE + 32'd8, 32'h0);
        z80_rd(8'h81);

        // Port move and IRQ
        wb(1'b1, BASE, 32'h140);
        wb(1'b0, BASE, 32'h0);
        z80_wr(8'h80, 8'h55);
        z80_wr(8'h40, 8'h66);
        check("irq_set", irq_out, {31'b0, m_irq_en & (rx_q.size() > 0)});
        wb(1'b0, BASE + 32'd8, 32'h0);
        wb(1'b0, BASE + 32'd4, 32'h0);
        @(negedge clk);
        check("irq_clr", irq_out, {31'b0, m_irq_en & (rx_q.size() > 0)});
        z80_rd(8'h80);

        // Full RX: Z80 push lands on the same edge as a WB pop
        for (int i = 0; i < DEPTH; i++) z80_wr(8'h40, 8'hC0 + 8'(i));
        wb(1'b0, BASE + 32'd8, 32'h0);
        @(negedge clk);
        z80_address_bus = 8'h40; z80_data_bus_in = 8'hEE; z80_write_strobe_b = 1'b0;
        repeat (2) @(negedge clk);
        exp = {23'b0, 1'b1, rx_q.pop_front()};
        rx_q.push_back(8'hEE);
        wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b0; wb_addr_in = BASE + 32'd4;
        @(posedge clk); #1;
        check("simul_ack", wb_ack_out, 32'd1);
        check("simul_rdata", wb_data_out, exp);
        @(negedge clk);
        wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
        repeat (3) @(negedge clk);
        z80_write_strobe_b = 1'b1;
        repeat (5) @(negedge clk);
        wb(1'b0, BASE + 32'd8, 32'h0);
        for (int i = 0; i <= DEPTH; i++) wb(1'b0, BASE + 32'd4, 32'h0);

        // Async reset while the Z80 read is being driven
        @(negedge clk);
        z80_address_bus = 8'h40; z80_read_strobe_b = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_dir", z80_bus_dir, 32'd1);
        check("pre_rst_out", z80_data_bus_out, 32'hFF);
        #1 reset_b = 1'b0;
        #1;
        check("rst_async_dir", z80_bus_dir, 32'd0);
        check("rst_async_out", z80_data_bus_out, 32'd0);
        @(negedge clk);
        z80_read_strobe_b = 1'b1;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("post_rst_irq", irq_out, 32'd0);
        check("post_rst_dir", z80_bus_dir, 32'd0);
        wb(1'b0, BASE + 32'd8, 32'h0);
        wb(1'b0, BASE, 32'h0);
        wb(1'b0, BASE + 32'd4, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
